// File: rtl/draw_station.sv
// Station sprite for the 96x64 OLED: border box with a tick-driven progress fill
// and a blinking border once full. Pixel output is registered (1-cycle latency).
//
// state | meaning
// IDLE  | waiting for start, fill cleared
// BUSY  | fill grows one column per tick
// READY | fill complete, border blinks until ack
module draw_station #(
  parameter int TOP_LEFT_X    = 0,
  parameter int TOP_LEFT_Y    = 0,
  parameter int LENGTH        = 12,
  parameter int WIDTH         = 12,
  parameter int BORDER        = 1,
  parameter int TICK_DIV      = 2500000,
  parameter int BLINK_STEPS   = 5,
  parameter logic [15:0] BORDER_COLOUR = 16'hFFFF,
  parameter logic [15:0] READY_COLOUR  = 16'hF800,
  parameter logic [15:0] FILL_COLOUR   = 16'h07E0,
  parameter logic [15:0] BG_COLOUR     = 16'h0000
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  input  logic        start,
  input  logic        ack,
  input  logic        abort,
  output logic        busy,
  output logic        ready,
  output logic [6:0]  fill,
  output logic [15:0] oled_data
);

  localparam int INNER_W = LENGTH - 2*BORDER;
  localparam logic [6:0]  FILL_MAX   = 7'(INNER_W);
  localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_STEPS - 1);
  localparam logic [7:0]  X0   = 8'(TOP_LEFT_X);
  localparam logic [7:0]  Y0   = 8'(TOP_LEFT_Y);
  localparam logic [7:0]  LEN8 = 8'(LENGTH);
  localparam logic [7:0]  WID8 = 8'(WIDTH);
  localparam logic [7:0]  B8   = 8'(BORDER);

  typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

  state_t      state, state_next;
  logic [6:0]  fill_next;
  logic [31:0] presc, presc_next;
  logic [31:0] blink_cnt, blink_next;
  logic        blink_phase, phase_next;
  logic        step;
  logic [7:0]  dx, dy;
  logic        in_box, on_border, in_fill;
  logic [15:0] pix_next;

  assign step = (presc == TICK_LAST);

  always_comb begin
    state_next = state;
    fill_next  = fill;
    presc_next = presc;
    blink_next = blink_cnt;
    phase_next = blink_phase;
    if (abort) begin
      state_next = IDLE;
      fill_next  = '0;
      presc_next = '0;
      phase_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = BUSY;
            fill_next  = '0;
            presc_next = '0;
          end
        end
        BUSY: begin
          if (step) begin
            presc_next = '0;
            fill_next  = fill + 7'd1;
            if (fill + 7'd1 == FILL_MAX) begin
              state_next = READY;
              blink_next = '0;
              phase_next = 1'b1;
            end
          end else begin
            presc_next = presc + 32'd1;
          end
        end
        READY: begin
          if (ack) begin
            state_next = IDLE;
            fill_next  = '0;
            presc_next = '0;
            phase_next = 1'b0;
          end else if (step) begin
            presc_next = '0;
            if (blink_cnt == BLINK_LAST) begin
              blink_next = '0;
              phase_next = ~blink_phase;
            end else begin
              blink_next = blink_cnt + 32'd1;
            end
          end else begin
            presc_next = presc + 32'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Offsets wrap to large values left/above the box, so one unsigned compare bounds each axis.
  always_comb begin
    dx        = {1'b0, x} - X0;
    dy        = {1'b0, y} - Y0;
    in_box    = (dx < LEN8) && (dy < WID8);
    on_border = (dx < B8) || (dx >= LEN8 - B8) || (dy < B8) || (dy >= WID8 - B8);
    in_fill   = dx < (B8 + {1'b0, fill});
    pix_next  = 16'h0000;
    if (in_box) begin
      if (on_border)
        pix_next = (state == READY && blink_phase) ? READY_COLOUR : BORDER_COLOUR;
      else if (in_fill)
        pix_next = FILL_COLOUR;
      else
        pix_next = BG_COLOUR;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fill        <= '0;
      presc       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      oled_data   <= 16'h0000;
    end else begin
      state       <= state_next;
      fill        <= fill_next;
      presc       <= presc_next;
      blink_cnt   <= blink_next;
      blink_phase <= phase_next;
      busy        <= (state_next == BUSY);
      ready       <= (state_next == READY);
      oled_data   <= pix_next;
    end
  end

endmodule
